kgp_fetch_queue: RTL and testbench

Parametrised instruction-fetch unit for the KGP RISC core, replacing the single-cycle program-counter path with a decoupled prefetcher. It keeps up to DEPTH instruction fetches in flight to an in-order instruction memory and buffers returned words with their PCs. It hands instructions to decode through a valid/ready handshake. A redirect from the jump/branch logic flushes the queue and any in-flight fetches.

---
 rtl/kgp_fetch_pkg.sv | 21 ++
 rtl/kgp_fetch_buf.sv | 43 ++++
 rtl/kgp_fetch_queue.sv | 99 +++++++++
 tb/tb_kgp_fetch_queue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/kgp_fetch_pkg.sv
// KGP fetch queue shared types.
// Slot record and pointer-width helper.
package kgp_fetch_pkg;

    localparam int KGP_XLEN    = 32;
    localparam int KGP_INSTR_W = 32;

    typedef struct packed {
        logic [KGP_XLEN-1:0]    pc;
        logic [KGP_INSTR_W-1:0] instr;
        logic                   filled;
    } slot_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/kgp_fetch_buf.sv
// KGP fetch queue slot storage.
// Reserve, fill and head-read ports with a flush clear.
module kgp_fetch_buf
    import kgp_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   rsv_en,
    input  logic [PW-1:0]          rsv_idx,
    input  logic [KGP_XLEN-1:0]    rsv_pc,
    input  logic                   fill_en,
    input  logic [PW-1:0]          fill_idx,
    input  logic [KGP_INSTR_W-1:0] fill_instr,
    input  logic [PW-1:0]          head_idx,
    output slot_t                  head
);

    slot_t slots [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
        end else begin
            if (rsv_en) begin
                slots[rsv_idx].pc     <= rsv_pc;
                slots[rsv_idx].filled <= 1'b0;
            end
            if (fill_en) begin
                slots[fill_idx].instr  <= fill_instr;
                slots[fill_idx].filled <= 1'b1;
            end
        end
    end

    assign head = slots[head_idx];

endmodule

// File: rtl/kgp_fetch_queue.sv
// KGP decoupled instruction prefetcher.
// Keeps up to DEPTH fetches buffered or in flight; redirect flushes.
module kgp_fetch_queue
    import kgp_fetch_pkg::*;
#(
    parameter int              XLEN     = KGP_XLEN,
    parameter int              INSTR_W  = KGP_INSTR_W,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               deq_valid,
    input  logic               deq_ready,
    output logic [INSTR_W-1:0] deq_instr,
    output logic [XLEN-1:0]    deq_pc
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [PW-1:0]   head_ptr, fill_ptr, tail_ptr;
    logic [CW-1:0]   used, drop_cnt, pend;
    logic [CW:0]     occ;
    logic            accept, rsp_live, rsp_fill, rsp_drop, deq;
    slot_t           head;

    assign occ            = {1'b0, used} + {1'b0, drop_cnt};
    assign imem_req_valid = rst && !redirect_valid && (occ < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // Responses with nothing live or pending-drop are protocol errors.
    assign rsp_live = imem_rsp_valid && (pend != '0 || drop_cnt != '0);
    assign rsp_drop = rsp_live && (drop_cnt != '0 || redirect_valid);
    assign rsp_fill = rsp_live && !rsp_drop;

    assign deq_valid = head.filled;
    assign deq_instr = head.filled ? head.instr : '0;
    assign deq_pc    = head.filled ? head.pc : '0;
    assign deq       = deq_valid && deq_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            head_ptr <= '0;
            fill_ptr <= '0;
            tail_ptr <= '0;
            used     <= '0;
            pend     <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            head_ptr <= '0;
            fill_ptr <= '0;
            tail_ptr <= '0;
            used     <= '0;
            pend     <= '0;
            drop_cnt <= drop_cnt + pend - CW'(rsp_live);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + PC_STEP;
                tail_ptr <= tail_ptr + PW'(1);
            end
            if (rsp_fill) fill_ptr <= fill_ptr + PW'(1);
            if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
            if (deq)      head_ptr <= head_ptr + PW'(1);
            used <= used + CW'(accept) - CW'(deq);
            pend <= pend + CW'(accept) - CW'(rsp_fill);
        end
    end

    kgp_fetch_buf #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .clr        (redirect_valid),
        .rsv_en     (accept),
        .rsv_idx    (tail_ptr),
        .rsv_pc     (fetch_pc),
        .fill_en    (rsp_fill),
        .fill_idx   (fill_ptr),
        .fill_instr (imem_rsp_data),
        .head_idx   (head_ptr),
        .head       (head)
    );

endmodule

// File: tb/tb_kgp_fetch_queue.sv
// Directed vector bench for kgp_fetch_queue.
// One record per cycle: inputs then expected outputs.
module tb_kgp_fetch_queue;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;

    kgp_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_instr      (deq_instr),
        .deq_pc         (deq_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        rn;
        bit        rdy;
        bit        rv;
        bit [31:0] rd;
        bit        rdr;
        bit [31:0] rpc;
        bit        dr;
        bit        e_req;
        bit [31:0] e_addr;
        bit        e_deq;
        bit [31:0] e_instr;
        bit [31:0] e_pc;
    } vec_t;

    vec_t vq[$];
    int   n_cmp;
    int   n_bad;

    task automatic v(input bit rn, input bit rdy, input bit rv,
                     input bit [31:0] rd, input bit rdr,
                     input bit [31:0] rpc, input bit dr,
                     input bit e_req, input bit [31:0] e_addr,
                     input bit e_deq, input bit [31:0] e_instr,
                     input bit [31:0] e_pc);
        vec_t t;
        t.rn = rn; t.rdy = rdy; t.rv = rv; t.rd = rd;
        t.rdr = rdr; t.rpc = rpc; t.dr = dr;
        t.e_req = e_req; t.e_addr = e_addr; t.e_deq = e_deq;
        t.e_instr = e_instr; t.e_pc = e_pc;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input bit rn, input bit rdy, input bit rv,
                         input bit [31:0] rd, input bit rdr,
                         input bit [31:0] rpc, input bit dr);
        rst            = rn;
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        deq_ready      = dr;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Stream: 1-cycle memory, decode always ready
        v(0,0,0,0,0,0,0, 0,32'h0,   0,0,0);
        v(1,1,0,0,0,0,1, 1,32'h0,   0,0,0);
        v(1,1,1,32'h10000000,0,0,1, 1,32'h4, 0,0,0);
        v(1,1,1,32'h10000004,0,0,1, 1,32'h8, 1,32'h10000000,32'h0);
        v(1,1,1,32'h10000008,0,0,1, 1,32'hC, 1,32'h10000004,32'h4);
        v(1,1,1,32'h1000000C,0,0,1, 1,32'h10, 1,32'h10000008,32'h8);
        v(1,1,1,32'h10000010,0,0,1, 1,32'h14, 1,32'h1000000C,32'hC);

        // Decode stalled: queue fills at 4, one deq frees one slot
        v(0,0,0,0,0,0,0, 0,32'h0,   0,0,0);
        v(1,1,0,0,0,0,0, 1,32'h0,   0,0,0);
        v(1,1,1,32'h20000000,0,0,0, 1,32'h4, 0,0,0);
        v(1,1,1,32'h20000004,0,0,0, 1,32'h8, 1,32'h20000000,32'h0);
        v(1,1,1,32'h20000008,0,0,0, 1,32'hC, 1,32'h20000000,32'h0);
        v(1,1,1,32'h2000000C,0,0,0, 0,32'h0, 1,32'h20000000,32'h0);
        v(1,1,0,0,0,0,1, 0,32'h0,   1,32'h20000000,32'h0);
        v(1,1,0,0,0,0,0, 1,32'h10,  1,32'h20000004,32'h4);
        v(1,1,0,0,0,0,0, 0,32'h0,   1,32'h20000004,32'h4);

        // Three in flight, redirect to 0x100, late responses dropped
        v(0,0,0,0,0,0,0, 0,32'h0,   0,0,0);
        v(1,1,0,0,0,0,1, 1,32'h0,   0,0,0);
        v(1,1,0,0,0,0,1, 1,32'h4,   0,0,0);
        v(1,1,0,0,0,0,1, 1,32'h8,   0,0,0);
        v(1,1,0,0,1,32'h100,1, 0,32'h0, 0,0,0);
        v(1,1,1,32'hDEAD0000,0,0,1, 1,32'h100, 0,0,0);
        v(1,1,1,32'hDEAD0004,0,0,1, 1,32'h104, 0,0,0);
        v(1,1,1,32'hDEAD0008,0,0,1, 1,32'h108, 0,0,0);
        v(1,1,1,32'h30000100,0,0,1, 1,32'h10C, 0,0,0);
        v(1,1,0,0,0,0,1, 0,32'h0,   1,32'h30000100,32'h100);
        v(1,0,0,0,0,0,1, 1,32'h110, 0,0,0);

        // Response and deq handshake in the redirect cycle
        v(0,0,0,0,0,0,0, 0,32'h0,   0,0,0);
        v(1,1,0,0,0,0,0, 1,32'h0,   0,0,0);
        v(1,1,1,32'h40000000,0,0,0, 1,32'h4, 0,0,0);
        v(1,0,0,0,0,0,0, 1,32'h8,   1,32'h40000000,32'h0);
        v(1,1,1,32'h40000004,1,32'h200,1, 0,32'h0, 1,32'h40000000,32'h0);
        v(1,1,0,0,0,0,1, 1,32'h200, 0,0,0);
        v(1,1,1,32'h40000200,0,0,1, 1,32'h204, 0,0,0);
        v(1,0,0,0,0,0,1, 1,32'h208, 1,32'h40000200,32'h200);
        v(1,0,1,32'h40000204,0,0,1, 1,32'h208, 0,0,0);
        v(1,0,0,0,0,0,1, 1,32'h208, 1,32'h40000204,32'h204);

        // PC wrap, then reset with 2 outstanding and 2 used
        v(0,0,0,0,0,0,0, 0,32'h0,   0,0,0);
        v(1,1,0,0,1,32'hFFFFFFFC,0, 0,32'h0, 0,0,0);
        v(1,1,0,0,0,0,0, 1,32'hFFFFFFFC, 0,0,0);
        v(1,1,1,32'h5000FFFC,0,0,0, 1,32'h0, 0,0,0);
        v(1,1,0,0,0,0,1, 1,32'h4,   1,32'h5000FFFC,32'hFFFFFFFC);
        v(0,1,0,0,0,0,0, 0,32'h0,   0,0,0);
        v(1,1,1,32'hBAD00000,0,0,0, 1,32'h0, 0,0,0);
        v(1,0,1,32'h60000000,0,0,0, 1,32'h4, 0,0,0);
        v(1,0,0,0,0,0,0, 1,32'h4,   1,32'h60000000,32'h0);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rn, vq[i].rdy, vq[i].rv, vq[i].rd,
                  vq[i].rdr, vq[i].rpc, vq[i].dr);
            #1;
            chk("req_valid", i, {31'b0, imem_req_valid},
                {31'b0, vq[i].e_req});
            if (vq[i].e_req || !vq[i].rn)
                chk("req_addr", i, imem_req_addr, vq[i].e_addr);
            chk("deq_valid", i, {31'b0, deq_valid},
                {31'b0, vq[i].e_deq});
            if (vq[i].e_deq || !vq[i].rn) begin
                chk("deq_instr", i, deq_instr, vq[i].e_instr);
                chk("deq_pc", i, deq_pc, vq[i].e_pc);
            end
        end

        // Request held stable while memory stalls, then withdrawn
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_valid", 100 + k, {31'b0, imem_req_valid}, 32'd1);
            chk("stall_addr", 100 + k, imem_req_addr, 32'h0);
            @(negedge clk);
        end
        drive(1, 0, 0, 0, 1, 32'h40, 1);
        #1;
        chk("withdraw", 103, {31'b0, imem_req_valid}, 32'd0);
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0, 0);
        #1;
        chk("redir_addr", 104, imem_req_addr, 32'h40);
        @(negedge clk);
        drive(1, 0, 1, 32'h70000040, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        begin
            int w;
            w = 0;
            while (!deq_valid && w < 5) begin
                @(negedge clk);
                w++;
            end
            #1;
            chk("wait_deq", 105, {31'b0, deq_valid}, 32'd1);
            chk("wait_pc", 105, deq_pc, 32'h40);
            chk("wait_instr", 105, deq_instr, 32'h70000040);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
